// File: rtl/adc_gate_pkg.sv
// Shared types and default widths for the ADC sweep gate.
package adc_gate_pkg;
  localparam int ADC_W     = 12;
  localparam int DEF_DLY_W = 12;
  localparam int DEF_LEN_W = 12;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_TRIG = 2'b01,
    DELAY     = 2'b10,
    CAPTURE   = 2'b11
  } gate_state_t;
endpackage

// File: rtl/adc_sweep_gate_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus a history flop
// that turns the synchronized level into a one-cycle rising-edge pulse.
module sync_edge (
  input  logic adclk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);
  logic s1_reg, s2_reg, s3_reg;

  always_ff @(posedge adclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= raw;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign level = s2_reg;
  assign rise  = s2_reg & ~s3_reg;
endmodule

// File: rtl/adc_sweep_gate.sv
// Sweep-triggered acquisition window: skips cfg_delay samples after each
// trigger, then passes exactly cfg_len samples framed by start/end pulses.
module adc_sweep_gate
  import adc_gate_pkg::*;
#(
  parameter int DLY_W = DEF_DLY_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             adclk,
  input  logic             rst_n,
  input  logic [ADC_W-1:0] a2d_in,
  input  logic             sweep_trig,
  input  logic             arm,
  input  logic [DLY_W-1:0] cfg_delay,
  input  logic [LEN_W-1:0] cfg_len,
  output logic [ADC_W-1:0] a2d_q,
  output logic             a2d_valid,
  output logic             line_start,
  output logic             line_end,
  output logic [CNT_W-1:0] line_cnt,
  output logic             busy,
  output logic             trig_ovf
);
  gate_state_t      state_reg, state_next;
  logic [DLY_W-1:0] dly_reg, dly_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [LEN_W-1:0] rem_reg, rem_next;
  logic [CNT_W-1:0] cnt_next;
  logic             valid_next, start_next, end_next, busy_next, ovf_next;
  logic             trig_edge, trig_level_unused, arm_s, arm_rise;

  sync_edge u_trig_sync (
    .adclk (adclk),
    .rst_n (rst_n),
    .raw   (sweep_trig),
    .level (trig_level_unused),
    .rise  (trig_edge)
  );

  sync_edge u_arm_sync (
    .adclk (adclk),
    .rst_n (rst_n),
    .raw   (arm),
    .level (arm_s),
    .rise  (arm_rise)
  );

  // rem_reg counts the samples still to emit, including the current one.
  always_comb begin
    state_next = state_reg;
    dly_next   = dly_reg;
    len_next   = len_reg;
    rem_next   = rem_reg;
    case (state_reg)
      IDLE: begin
        if (arm_s) state_next = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        if (!arm_s) begin
          state_next = IDLE;
        end else if (trig_edge && (cfg_len != '0)) begin
          dly_next = cfg_delay;
          len_next = cfg_len;
          if (cfg_delay != '0) begin
            state_next = DELAY;
          end else begin
            state_next = CAPTURE;
            rem_next   = cfg_len;
          end
        end
      end
      DELAY: begin
        if (dly_reg <= DLY_W'(1)) begin
          state_next = CAPTURE;
          rem_next   = len_reg;
        end else begin
          dly_next = dly_reg - DLY_W'(1);
        end
      end
      CAPTURE: begin
        if (rem_reg <= LEN_W'(1)) begin
          state_next = arm_s ? WAIT_TRIG : IDLE;
        end else begin
          rem_next = rem_reg - LEN_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    valid_next = (state_next == CAPTURE);
    start_next = valid_next && (state_reg != CAPTURE);
    end_next   = valid_next && (rem_next == LEN_W'(1));
    busy_next  = (state_next == DELAY) || (state_next == CAPTURE);
    ovf_next   = trig_edge && ((state_reg == DELAY) || (state_reg == CAPTURE));

    cnt_next = line_cnt;
    if (arm_rise)      cnt_next = '0;
    else if (end_next) cnt_next = line_cnt + CNT_W'(1);
  end

  always_ff @(posedge adclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      dly_reg    <= '0;
      len_reg    <= '0;
      rem_reg    <= '0;
      a2d_q      <= '0;
      a2d_valid  <= 1'b0;
      line_start <= 1'b0;
      line_end   <= 1'b0;
      line_cnt   <= '0;
      busy       <= 1'b0;
      trig_ovf   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      dly_reg    <= dly_next;
      len_reg    <= len_next;
      rem_reg    <= rem_next;
      a2d_q      <= a2d_in;
      a2d_valid  <= valid_next;
      line_start <= start_next;
      line_end   <= end_next;
      line_cnt   <= cnt_next;
      busy       <= busy_next;
      trig_ovf   <= ovf_next;
    end
  end
endmodule

// File: tb/tb_adc_sweep_gate.sv
// Scoreboard bench for adc_sweep_gate: triggers predict the sample window
// from the timing rules; a monitor checks every DUT cycle against it.
module tb_adc_sweep_gate;
  localparam int DLY_W   = 12;
  localparam int LEN_W   = 12;
  localparam int CNT_W   = 4;
  localparam int CNT_MOD = 1 << CNT_W;
  localparam int MAXC    = 30000;

  logic             adclk = 1'b0;
  logic             rst_n = 1'b0;
  logic [11:0]      a2d_in = '0;
  logic             sweep_trig = 1'b0;
  logic             arm = 1'b0;
  logic [DLY_W-1:0] cfg_delay = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic [11:0]      a2d_q;
  logic             a2d_valid, line_start, line_end, busy, trig_ovf;
  logic [CNT_W-1:0] line_cnt;

  adc_sweep_gate #(.DLY_W(DLY_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .adclk      (adclk),
    .rst_n      (rst_n),
    .a2d_in     (a2d_in),
    .sweep_trig (sweep_trig),
    .arm        (arm),
    .cfg_delay  (cfg_delay),
    .cfg_len    (cfg_len),
    .a2d_q      (a2d_q),
    .a2d_valid  (a2d_valid),
    .line_start (line_start),
    .line_end   (line_end),
    .line_cnt   (line_cnt),
    .busy       (busy),
    .trig_ovf   (trig_ovf)
  );

  always #5 adclk = ~adclk;

  typedef struct {
    int cyc;
    bit first;
    bit last;
    int cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          ovf_q[$];
  bit          busy_exp[MAXC];
  logic [11:0] data_at[MAXC];
  int          edge_n = 0;
  int          tests = 0;
  int          fails = 0;
  int          model_cnt = 0;
  bit          armed = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, req);
    end
  endtask

  // Fresh random sample on every falling edge.
  always @(negedge adclk) a2d_in = 12'($urandom);

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge adclk);
      edge_n++;
      data_at[edge_n] = a2d_in;
      #1;
      if (!rst_n) begin
        chk("reset_outputs", int'({a2d_q, a2d_valid, line_start, line_end, line_cnt, busy, trig_ovf}), 0);
      end else begin
        chk("a2d_q", int'(a2d_q), int'(data_at[edge_n]));
        chk("busy", int'(busy), int'(busy_exp[edge_n]));
        if (a2d_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", int'(a2d_valid), 0);
          end else begin
            e = exp_q.pop_front();
            chk("valid_cycle", edge_n, e.cyc);
            chk("line_start", int'(line_start), int'(e.first));
            chk("line_end", int'(line_end), int'(e.last));
            chk("line_cnt", int'(line_cnt), e.cnt);
          end
        end else begin
          if (exp_q.size() != 0 && exp_q[0].cyc <= edge_n) begin
            chk("a2d_valid", int'(a2d_valid), 1);
            void'(exp_q.pop_front());
          end
          chk("markers_outside_window", int'({line_start, line_end}), 0);
        end
        if (trig_ovf) begin
          if (ovf_q.size() == 0) chk("unexpected_ovf", int'(trig_ovf), 0);
          else chk("ovf_cycle", edge_n, ovf_q.pop_front());
        end else if (ovf_q.size() != 0 && ovf_q[0] <= edge_n) begin
          chk("trig_ovf", int'(trig_ovf), 1);
          void'(ovf_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #(200000);
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1, "watchdog");
  end

  // Called just after a falling edge; the next rising edge is edge k.
  task automatic fire(input int d, input int l);
    int k;
    exp_t e;
    cfg_delay = DLY_W'(d);
    cfg_len   = LEN_W'(l);
    k = edge_n + 1;
    if (busy_exp[k+1]) begin
      ovf_q.push_back(k + 2);
    end else if (armed && l != 0) begin
      for (int c = k + 2; c <= k + 1 + d + l; c++) busy_exp[c] = 1'b1;
      for (int i = 0; i < l; i++) begin
        e.cyc   = k + 2 + d + i;
        e.first = (i == 0);
        e.last  = (i == l - 1);
        e.cnt   = (i == l - 1) ? (model_cnt + 1) % CNT_MOD : model_cnt;
        exp_q.push_back(e);
      end
      model_cnt = (model_cnt + 1) % CNT_MOD;
    end
    sweep_trig = 1'b1;
    repeat (2) @(negedge adclk);
    sweep_trig = 1'b0;
    @(negedge adclk);
    cfg_delay = DLY_W'($urandom);
    cfg_len   = LEN_W'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || ovf_q.size() != 0 || busy_exp[edge_n]) && n < 1000) begin
      @(negedge adclk);
      n++;
    end
    if (n >= 1000) chk("drain_timeout", n, 0);
    repeat (3) @(negedge adclk);
    chk("line_cnt_idle", int'(line_cnt), model_cnt);
  endtask

  task automatic set_arm(input bit v);
    arm = v;
    if (v && !armed) model_cnt = 0;
    armed = v;
    repeat (6) @(negedge adclk);
    chk("line_cnt_after_arm", int'(line_cnt), model_cnt);
  endtask

  task automatic mid_line_reset();
    rst_n = 1'b0;
    #1;
    chk("async_reset", int'({a2d_valid, line_end, busy, line_cnt}), 0);
    exp_q.delete();
    ovf_q.delete();
    for (int c = edge_n; c < MAXC; c++) busy_exp[c] = 1'b0;
    model_cnt = 0;
    repeat (2) @(negedge adclk);
    rst_n = 1'b1;
    repeat (6) @(negedge adclk);
  endtask

  initial begin : stimulus
    int d, l;
    repeat (3) @(negedge adclk);
    rst_n = 1'b1;
    @(negedge adclk);
    set_arm(1'b1);

    fire(0, 8);                              // plain line, no delay
    drain();
    fire(5, 4);                              // delayed line
    drain();
    fire(0, 16);                             // overlapping trigger mid-line
    repeat (2) @(negedge adclk);
    fire(0, 4);
    drain();
    fire(2, 6);                              // trigger lands on line_end
    repeat (4) @(negedge adclk);
    fire(0, 4);
    drain();

    fire(1, 12);                             // arm drops at 2nd sample
    @(negedge adclk);
    arm = 1'b0;
    armed = 1'b0;
    drain();
    fire(0, 4);
    drain();
    set_arm(1'b1);

    fire(0, 16);                             // reset mid-capture
    repeat (4) @(negedge adclk);
    mid_line_reset();
    fire(0, 8);
    drain();

    for (int i = 0; i < 17; i++) begin      // counter wrap
      fire($urandom_range(0, 3), 4);
      drain();
    end
    set_arm(1'b0);
    set_arm(1'b1);
    fire(0, 0);                              // zero length ignored
    drain();

    for (int i = 0; i < 40; i++) begin
      d = $urandom_range(0, 6);
      l = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
      fire(d, l);
      repeat ($urandom_range(1, 14)) @(negedge adclk);
    end
    drain();

    chk("scoreboard_empty", exp_q.size() + ovf_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
